// File: rtl/odometry_accumulator.sv
// Multi-channel wheel odometry: saturating signed distance per channel plus a
// per-window signed speed sample delivered over a valid/ready handshake.
module odometry_accumulator #(
  parameter int N_CH           = 2,
  parameter int DIST_PER_PULSE = 628,
  parameter int ACC_W          = 32,
  parameter int WINDOW_CYCLES  = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [N_CH-1:0]       incrementa_cw,
  input  logic [N_CH-1:0]       incrementa_ccw,
  output logic [N_CH*ACC_W-1:0] distance,
  output logic [N_CH-1:0]       saturated,
  output logic [N_CH*ACC_W-1:0] speed,
  output logic                  speed_valid,
  input  logic                  speed_ready,
  output logic                  overrun
);

  localparam int NET_W = $clog2(WINDOW_CYCLES + 1) + 1;
  localparam int CNT_W = $clog2(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic signed [ACC_W:0] MAX_V    = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V    = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] STEP_V   = (ACC_W+1)'(DIST_PER_PULSE);
  localparam logic [ACC_W-1:0]      DPP_A    = ACC_W'(DIST_PER_PULSE);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  logic signed [ACC_W-1:0] r_dist  [N_CH];
  logic signed [NET_W-1:0] r_net   [N_CH];
  logic [ACC_W-1:0]        r_speed [N_CH];
  logic [N_CH-1:0]         r_sat;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_overrun;
  state_t                  r_state;
  state_t                  w_state_next;
  logic                    w_term;
  logic                    w_ovr_set;

  logic signed [ACC_W-1:0] w_dist_next [N_CH];
  logic signed [NET_W-1:0] w_net_tot   [N_CH];
  logic [ACC_W-1:0]        w_speed_new [N_CH];
  logic [N_CH-1:0]         w_clamp;

  assign w_term = (r_cnt == LAST_CNT);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic                    w_up;
      logic                    w_dn;
      logic signed [ACC_W:0]   w_sum;
      logic signed [ACC_W-1:0] w_net_ext;

      // Simultaneous CW and CCW pulses cancel.
      assign w_up  = incrementa_cw[gi] & ~incrementa_ccw[gi];
      assign w_dn  = incrementa_ccw[gi] & ~incrementa_cw[gi];
      assign w_sum = {r_dist[gi][ACC_W-1], r_dist[gi]}
                   + (w_up ? STEP_V : (w_dn ? -STEP_V : {(ACC_W+1){1'b0}}));

      assign w_clamp[gi]     = (w_sum > MAX_V) || (w_sum < MIN_V);
      assign w_dist_next[gi] = (w_sum > MAX_V) ? MAX_V[ACC_W-1:0] :
                               (w_sum < MIN_V) ? MIN_V[ACC_W-1:0] : w_sum[ACC_W-1:0];

      // The terminal-cycle pulse belongs to the window that is closing.
      assign w_net_tot[gi]   = r_net[gi]
                             + (w_up ? NET_W'(1) : (w_dn ? {NET_W{1'b1}} : {NET_W{1'b0}}));
      assign w_net_ext       = ACC_W'(w_net_tot[gi]);
      assign w_speed_new[gi] = w_net_ext * DPP_A;

      assign distance[gi*ACC_W +: ACC_W] = r_dist[gi];
      assign speed[gi*ACC_W +: ACC_W]    = r_speed[gi];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_ovr_set    = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_term) w_state_next = S_FULL;
      end
      S_FULL: begin
        if (w_term) w_ovr_set = ~speed_ready;
        else if (speed_ready) w_state_next = S_EMPTY;
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        r_dist[i]  <= '0;
        r_net[i]   <= '0;
        r_speed[i] <= '0;
      end
      r_sat     <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
      r_state   <= S_EMPTY;
    end else if (clear) begin
      for (int i = 0; i < N_CH; i++) begin
        r_dist[i]  <= '0;
        r_net[i]   <= '0;
        r_speed[i] <= '0;
      end
      r_sat     <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
      r_state   <= S_EMPTY;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        r_dist[i] <= w_dist_next[i];
        r_net[i]  <= w_term ? {NET_W{1'b0}} : w_net_tot[i];
        if (w_term) r_speed[i] <= w_speed_new[i];
      end
      r_sat   <= r_sat | w_clamp;
      r_cnt   <= w_term ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
      r_state <= w_state_next;
      if (w_ovr_set) r_overrun <= 1'b1;
    end
  end

  assign saturated   = r_sat;
  assign speed_valid = (r_state == S_FULL);
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_odometry_accumulator.sv
// Bench for odometry_accumulator: two instances (32-bit and 12-bit words) share
// one directed stimulus stream and are compared each cycle to an arithmetic model.
module tb_odometry_accumulator;

  localparam int DPP = 628;
  localparam int WIN = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        speed_ready = 1'b0;
  logic [1:0]  cw = 2'b00;
  logic [1:0]  ccw = 2'b00;

  logic [63:0] dist_a, spd_a;
  logic [1:0]  sat_a;
  logic        valid_a, ovr_a;
  logic [23:0] dist_b, spd_b;
  logic [1:0]  sat_b;
  logic        valid_b, ovr_b;

  int checks = 0;
  int errors = 0;

  // Model state, indexed [instance][channel]; instance 0 is 32-bit, 1 is 12-bit.
  longint m_dist [2][2];
  bit     m_sat  [2][2];
  longint m_spd  [2][2];
  longint m_net  [2];
  int     m_cnt;
  bit     m_full;
  bit     m_ovr;

  always #5 clk = ~clk;

  odometry_accumulator #(.N_CH(2), .DIST_PER_PULSE(DPP), .ACC_W(32), .WINDOW_CYCLES(WIN)) dut_a (
    .clk(clk), .reset(reset), .clear(clear),
    .incrementa_cw(cw), .incrementa_ccw(ccw),
    .distance(dist_a), .saturated(sat_a), .speed(spd_a),
    .speed_valid(valid_a), .speed_ready(speed_ready), .overrun(ovr_a)
  );

  odometry_accumulator #(.N_CH(2), .DIST_PER_PULSE(DPP), .ACC_W(12), .WINDOW_CYCLES(WIN)) dut_b (
    .clk(clk), .reset(reset), .clear(clear),
    .incrementa_cw(cw), .incrementa_ccw(ccw),
    .distance(dist_b), .saturated(sat_b), .speed(spd_b),
    .speed_valid(valid_b), .speed_ready(speed_ready), .overrun(ovr_b)
  );

  function automatic int width(int d);
    return (d == 0) ? 32 : 12;
  endfunction

  function automatic longint wrap(longint v, int w);
    longint m = longint'(1) << w;
    longint r = v & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic longint dut_dist(int d, int ch);
    if (d == 0) return longint'($signed(dist_a[ch*32 +: 32]));
    return longint'($signed(dist_b[ch*12 +: 12]));
  endfunction

  function automatic longint dut_spd(int d, int ch);
    if (d == 0) return longint'($signed(spd_a[ch*32 +: 32]));
    return longint'($signed(spd_b[ch*12 +: 12]));
  endfunction

  function automatic longint dut_sat(int d, int ch);
    return (d == 0) ? longint'(sat_a[ch]) : longint'(sat_b[ch]);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < 2; ch++) begin
        m_dist[d][ch] = 0;
        m_sat[d][ch]  = 1'b0;
        m_spd[d][ch]  = 0;
      end
    m_net[0] = 0;
    m_net[1] = 0;
    m_cnt  = 0;
    m_full = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic model_update();
    bit     term;
    int     s;
    longint nd, tot, lim;
    if (clear) begin
      model_reset();
      return;
    end
    term = (m_cnt == WIN - 1);
    for (int ch = 0; ch < 2; ch++) begin
      s = (cw[ch] && !ccw[ch]) ? 1 : ((ccw[ch] && !cw[ch]) ? -1 : 0);
      for (int d = 0; d < 2; d++) begin
        lim = longint'(1) << (width(d) - 1);
        nd  = m_dist[d][ch] + longint'(s * DPP);
        if (nd > lim - 1) begin
          nd = lim - 1;
          m_sat[d][ch] = 1'b1;
        end else if (nd < -lim) begin
          nd = -lim;
          m_sat[d][ch] = 1'b1;
        end
        m_dist[d][ch] = nd;
      end
      tot = m_net[ch] + s;
      if (term) begin
        for (int d = 0; d < 2; d++) m_spd[d][ch] = wrap(tot * DPP, width(d));
        m_net[ch] = 0;
      end else begin
        m_net[ch] = tot;
      end
    end
    if (term) begin
      if (m_full && !speed_ready) m_ovr = 1'b1;
      m_full = 1'b1;
    end else if (m_full && speed_ready) begin
      m_full = 1'b0;
    end
    m_cnt = term ? 0 : m_cnt + 1;
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 2; ch++) begin
        chk($sformatf("distance i%0d ch%0d", d, ch), dut_dist(d, ch), m_dist[d][ch]);
        chk($sformatf("saturated i%0d ch%0d", d, ch), dut_sat(d, ch), longint'(m_sat[d][ch]));
        chk($sformatf("speed i%0d ch%0d", d, ch), dut_spd(d, ch), m_spd[d][ch]);
      end
    end
    chk("speed_valid i0", longint'(valid_a), longint'(m_full));
    chk("speed_valid i1", longint'(valid_b), longint'(m_full));
    chk("overrun i0", longint'(ovr_a), longint'(m_ovr));
    chk("overrun i1", longint'(ovr_b), longint'(m_ovr));
  end

  task automatic cyc(input logic [1:0] c, input logic [1:0] cc, input logic rdy);
    cw = c;
    ccw = cc;
    speed_ready = rdy;
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(2'b00, 2'b00, 1'b0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(2'b00, 2'b00, 1'b0);
    clear = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset distance0", dut_dist(0, 0), 0);
    chk("reset speed_valid", longint'(valid_a), 0);
    reset = 1'b0;

    $display("test 1: cw pulses ch0, ccw pulse ch1");
    do_clear();
    cyc(2'b01, 2'b00, 1'b0);  chk("t1 dist0 #1", dut_dist(0, 0), 628);
    cyc(2'b00, 2'b00, 1'b0);
    cyc(2'b01, 2'b00, 1'b0);  chk("t1 dist0 #2", dut_dist(0, 0), 1256);
    cyc(2'b00, 2'b10, 1'b0);  chk("t1 dist1", dut_dist(0, 1), -628);
    cyc(2'b01, 2'b00, 1'b0);  chk("t1 dist0 #3", dut_dist(0, 0), 1884);
    idle(4);                  chk("t1 valid before end", longint'(valid_a), 0);
    idle(1);
    chk("t1 speed0", dut_spd(0, 0), 1884);
    chk("t1 speed1", dut_spd(0, 1), -628);
    chk("t1 valid", longint'(valid_a), 1);

    $display("test 2: simultaneous cw and ccw, second unread window end");
    cyc(2'b01, 2'b01, 1'b0);  chk("t2 dist0 held", dut_dist(0, 0), 1884);
    idle(9);
    chk("t2 speed0", dut_spd(0, 0), 0);
    chk("t2 overrun", longint'(ovr_a), 1);
    chk("t2 valid", longint'(valid_a), 1);

    $display("test 4: accept sample");
    cyc(2'b00, 2'b00, 1'b1);
    chk("t4 valid after accept", longint'(valid_a), 0);
    chk("t4 overrun sticky", longint'(ovr_a), 1);

    $display("test 5: accept on terminal cycle, terminal-cycle pulse");
    do_clear();
    idle(10);                 chk("t5 first valid", longint'(valid_a), 1);
    idle(4);
    cyc(2'b10, 2'b00, 1'b0);
    idle(4);
    cyc(2'b01, 2'b00, 1'b1);
    chk("t5 valid kept", longint'(valid_a), 1);
    chk("t5 no overrun", longint'(ovr_a), 0);
    chk("t5 speed1", dut_spd(0, 1), 628);
    chk("t5 speed0 terminal pulse", dut_spd(0, 0), 628);
    idle(10);
    chk("t5 next window speed0", dut_spd(0, 0), 0);

    $display("test 3: saturation on 12-bit instance");
    do_clear();
    cyc(2'b01, 2'b00, 1'b0);  chk("t3 dist #1", dut_dist(1, 0), 628);
    cyc(2'b01, 2'b00, 1'b0);  chk("t3 dist #2", dut_dist(1, 0), 1256);
    cyc(2'b01, 2'b00, 1'b0);  chk("t3 dist #3", dut_dist(1, 0), 1884);
    cyc(2'b01, 2'b00, 1'b0);
    chk("t3 dist clamp", dut_dist(1, 0), 2047);
    chk("t3 sat set", dut_sat(1, 0), 1);
    chk("t3 wide dist", dut_dist(0, 0), 2512);
    cyc(2'b00, 2'b01, 1'b0);
    chk("t3 dist off limit", dut_dist(1, 0), 1419);
    chk("t3 sat sticky", dut_sat(1, 0), 1);
    do_clear();
    chk("t3 dist cleared", dut_dist(1, 0), 0);
    chk("t3 sat cleared", dut_sat(1, 0), 0);

    $display("test 6: asynchronous reset mid-window");
    cyc(2'b01, 2'b00, 1'b0);
    cyc(2'b01, 2'b00, 1'b0);  chk("t6 dist before reset", dut_dist(0, 0), 1256);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6 dist async", dut_dist(0, 0), 0);
    chk("t6 valid async", longint'(valid_a), 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    idle(9);                  chk("t6 no early sample", longint'(valid_a), 0);
    idle(1);
    chk("t6 valid full window", longint'(valid_a), 1);
    chk("t6 speed0", dut_spd(0, 0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/odometry_accumulator.md
Name: odometry_accumulator

Overview:
Multi-channel odometry block for the Cyclone Cruiser wheel encoders. Each channel takes single-cycle CW/CCW step pulses from the encoder decoder and keeps a signed, saturating running distance in mm. It also produces a per-window signed speed sample (mm per window) for every channel and delivers the speed samples to the controller through a valid/ready handshake. It sits between the encoder step detectors and the navigation/telemetry logic.

Parameters:
N_CH, 2, number of independent encoder channels (1..8)
DIST_PER_PULSE, 628, mm travelled per step pulse (positive integer, < 2^(ACC_W-2))
ACC_W, 32, width of each signed distance and speed word
WINDOW_CYCLES, 50000000, speed sampling window length in clk cycles (>= 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous clear of all accumulators, window, flags and handshake
incrementa_cw  in  N_CH  per-channel CW step pulse, one cycle wide
incrementa_ccw  in  N_CH  per-channel CCW step pulse, one cycle wide
distance  out  N_CH*ACC_W  signed running distance per channel in mm, ch i at [i*ACC_W +: ACC_W]
saturated  out  N_CH  sticky flag per channel, distance hit its positive or negative limit
speed  out  N_CH*ACC_W  signed mm per window per channel, same packing as distance
speed_valid  out  1  speed holds an unread sample
speed_ready  in  1  consumer accepts the sample
overrun  out  1  sticky flag, a sample was overwritten while still unread

Behaviour:
- Reset is asynchronous and active-high. All outputs and internal counters go to 0; speed_valid=0.
- Priority per cycle: reset > clear > normal operation. While clear=1, pulses in that cycle are ignored. After clear, the window counter restarts at 0.
- Per-channel step value is derived as follows:
  - cw only: +DIST_PER_PULSE.
  - ccw only: -DIST_PER_PULSE.
  - both or neither: 0. Simultaneous pulses cancel, with no preference for either direction.
- Distance update:
  - distance_i <= distance_i + step, registered. The pulse is visible on distance the cycle after it is sampled (latency 1).
  - Arithmetic is done at ACC_W+1 bits, then clamped to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1].
  - On clamp, saturated_i <= 1. It stays set until clear or reset.
  - A saturated channel still moves away from the limit on opposite-direction pulses.
- Window counter:
  - Counts 0..WINDOW_CYCLES-1 and wraps.
  - Each channel keeps a signed net pulse count for the current window, width clog2(WINDOW_CYCLES+1)+1. It cannot overflow because there is at most 1 pulse per cycle.
- On the terminal cycle (count == WINDOW_CYCLES-1):
  - speed_i <= (net_i + this cycle's step sign) * DIST_PER_PULSE, truncated to ACC_W. Parameter limits guarantee a fit for sane windows; this is a documented integration constraint.
  - Net counts reset to 0 for the next window. The terminal-cycle pulse counts in the closing window, not the next one.
- Handshake, two-state FSM:
  - EMPTY: speed_valid=0. Goes to FULL at window end.
  - FULL: speed_valid=1. speed is held stable while valid && !ready.
    - speed_valid && speed_ready in a non-terminal cycle -> EMPTY next cycle.
    - Window end while FULL and not accepted in the same cycle -> speed is overwritten, stays FULL, overrun <= 1 (sticky until clear/reset).
    - Window end in the same cycle as acceptance -> the new sample loads, stays FULL, no overrun.
- distance and saturated are unaffected by the handshake state.
- A reset mid-window discards the partial window. No sample is produced for it.

Test Plan:
1. N_CH=2, WINDOW_CYCLES=10, ACC_W=32: 3 cw pulses on ch0, 1 ccw on ch1 -> one cycle after each pulse distance0 steps 628/1256/1884, distance1=-628; at window end speed0=1884, speed1=-628, speed_valid=1.
2. Same cycle cw=1 and ccw=1 on ch0 -> distance0 unchanged; window net 0 -> speed0=0.
3. ACC_W=12: 4 cw pulses -> distance 628, 1256, 1884, then 2047 with saturated0=1; 1 ccw -> 1419, saturated0 stays 1; clear -> distance 0, saturated0=0.
4. speed_ready held 0 across two window ends -> second sample replaces first, overrun=1, speed_valid=1; speed_ready=1 for one cycle -> speed_valid=0 next cycle.
5. speed_ready=1 exactly on the terminal cycle with valid=1 -> new sample loaded, speed_valid stays 1, overrun stays 0.
6. Async reset asserted mid-window between clock edges after 2 pulses -> all outputs 0 immediately; after release, the first window needs a full 10 cycles and speed=0 if there are no pulses.
